bit_iter: RTL and testbench

//   Set-bit iterator: accepts a W-bit word, then emits the index of every set
//   bit, lowest first, one per cycle on a valid/ready stream.

---
 rtl/bit_iter.sv | 71 +++++++
 tb/tb_bit_iter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bit_iter.sv
// bit_iter: set-bit iterator streaming the index of each set bit, lowest first
module ctz #(
  parameter int ORDER = 3,
  localparam int W = 2**ORDER
) (
  input  logic [W-1:0]     data,
  output logic [ORDER-1:0] index
);
  // lowest set bit wins by scanning from the top down; an all-zero word yields 0
  always_comb begin
    index = '0;
    for (int i = W - 1; i >= 0; i--)
      if (data[i]) index = i[ORDER-1:0];
  end
endmodule

module bit_iter #(
  parameter int ORDER = 3,
  localparam int W = 2**ORDER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ORDER-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic [ORDER:0]   done_count
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic [W-1:0] word, rest;
  logic [ORDER:0] count;
  assign rest = word & (word - 1'b1);
  ctz #(.ORDER(ORDER)) u_ctz (.data(word), .index(out_index));
  assign in_ready  = state == IDLE;
  assign out_valid = state == SCAN;
  assign out_last  = out_valid && rest == '0;
  // accept a word, strip one set bit per accepted beat, pulse done when exhausted
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state      <= IDLE;
      word       <= '0;
      count      <= '0;
      done       <= 1'b0;
      done_count <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && in_valid) begin
        if (in_data != '0) begin
          word  <= in_data;
          count <= '0;
          state <= SCAN;
        end else begin
          done       <= 1'b1;
          done_count <= '0;
        end
      end else if (state == SCAN && out_ready) begin
        word  <= rest;
        count <= count + 1'b1;
        if (rest == '0) begin
          state      <= IDLE;
          done       <= 1'b1;
          done_count <= count + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_bit_iter.sv
// tb_bit_iter: scoreboard bench for the set-bit iterator
module tb_bit_iter;
  logic       clock = 0, reset, in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic [7:0] in_data;
  logic [2:0] out_index;
  logic [3:0] done_count;
  int n_checks = 0, n_fail = 0;
  int beat_q[$];
  int done_q[$];

  bit_iter dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .done(done), .done_count(done_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // beat encoding: index*2 + last
  task automatic push_beat(input int idx, input int last);
    beat_q.push_back(idx * 2 + last);
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1;
    in_data  = d;
    @(posedge clock);
    #1 in_valid = 0;
    in_data = 8'hxx;
  endtask

  task automatic drain();
    int k = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0) && k < 40) begin
      @(negedge clock);
      k++;
    end
    #1 chk("drain_timeout", int'(beat_q.size() + done_q.size()), 0);
    @(posedge clock);
    #1;
  endtask

  // monitor: compare every presented beat and done pulse against the scoreboard
  always @(negedge clock) if (!reset) begin
    int e;
    if (out_valid) begin
      if (beat_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = out_ready ? beat_q.pop_front() : beat_q[0];
        chk(out_ready ? "index" : "held_index", int'(out_index), e / 2);
        chk(out_ready ? "last" : "held_last", int'(out_last), e % 2);
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_count", int'(done_count), done_q.pop_front());
    end
  end

  initial begin
    reset = 1; in_valid = 0; in_data = 0; out_ready = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_done_count", int'(done_count), 0);
    @(posedge clock);
    #1;
    // A5: 0,2,5,7 back-to-back then done=4
    push_beat(0, 0); push_beat(2, 0); push_beat(5, 0); push_beat(7, 1);
    done_q.push_back(4);
    send(8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("a5_valid", int'(out_valid), 1);
      chk("a5_in_ready", int'(in_ready), 0);
    end
    @(negedge clock);
    chk("a5_done", int'(done), 1);
    chk("a5_in_ready_back", int'(in_ready), 1);
    drain();
    // zero word: no beat, done=0
    done_q.push_back(0);
    send(8'h00);
    @(negedge clock);
    chk("zero_valid", int'(out_valid), 0);
    chk("zero_done", int'(done), 1);
    chk("zero_in_ready", int'(in_ready), 1);
    drain();
    // 81 under backpressure
    out_ready = 0;
    push_beat(0, 0); push_beat(7, 1);
    done_q.push_back(2);
    send(8'h81);
    repeat (3) begin
      @(negedge clock);
      chk("bp_valid", int'(out_valid), 1);
    end
    @(posedge clock);
    #1 out_ready = 1;
    drain();
    // FF: all indices then done=8
    for (int i = 0; i < 8; i++) push_beat(i, i == 7);
    done_q.push_back(8);
    send(8'hFF);
    drain();
    // F0 with reset after two beats
    push_beat(4, 0); push_beat(5, 0);
    send(8'hF0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1;
    #1 chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_pending", int'(beat_q.size()), 0);
    @(posedge clock);
    #1 reset = 0;
    repeat (3) @(negedge clock);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_done", int'(done), 0);
    @(posedge clock);
    #1;
    push_beat(1, 1);
    done_q.push_back(1);
    send(8'h02);
    drain();
    repeat (3) @(negedge clock);
    chk("final_idle_valid", int'(out_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
